sobel_edge_filter: RTL and testbench

- Downstream neighbour of the 3-row pixel loader: consumes one 3x3 window per valid beat and computes a Sobel gradient magnitude.
- Produces a saturated 8-bit edge magnitude and a thresholded edge bit, with row and column position tracking and end-of-line / end-of-frame markers.
- Fully pipelined with a fixed latency and no backpressure; its output feeds the result writer.

---
 rtl/sobel_edge_filter.sv | 134 +++++++++++++
 tb/tb_sobel_edge_filter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sobel_edge_filter.sv
// Sobel edge filter: 3x3 window in, saturated |Gx|+|Gy| and thresholded
// edge bit out, 3-stage pipeline with row/column tagging (eol/eof).
// Ports: clk, rstN (async low); window_in/window_in_valid in; threshold in;
//        edge_mag, edge_bit, edge_valid, edge_eol, edge_eof out.
module sobel_edge_filter #(
  parameter int ITEM_SIZE    = 8,
  parameter int IMAGE_WIDTH  = 512,
  parameter int IMAGE_HEIGHT = 512
) (
  input  logic                   clk,
  input  logic                   rstN,
  input  logic [9*ITEM_SIZE-1:0] window_in,
  input  logic                   window_in_valid,
  input  logic [ITEM_SIZE-1:0]   threshold,
  output logic [ITEM_SIZE-1:0]   edge_mag,
  output logic                   edge_bit,
  output logic                   edge_valid,
  output logic                   edge_eol,
  output logic                   edge_eof
);

  localparam int CW = $clog2(IMAGE_WIDTH);
  localparam int RW = $clog2(IMAGE_HEIGHT);
  localparam int SW = ITEM_SIZE + 2;

  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;

  logic [SW-1:0] p [3][3];

  always_comb begin
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        p[r][c] = {2'b00, window_in[(3*r+c)*ITEM_SIZE +: ITEM_SIZE]};
      end
    end
  end

  logic last_col, last_row, qual;

  assign last_col = (col_cnt == CW'(IMAGE_WIDTH - 1));
  assign last_row = (row_cnt == RW'(IMAGE_HEIGHT - 3));
  // The first two beats of each row still carry columns of the previous row.
  assign qual     = window_in_valid && (col_cnt >= CW'(2));

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      col_cnt <= '0;
      row_cnt <= '0;
    end else if (window_in_valid) begin
      if (last_col) begin
        col_cnt <= '0;
        row_cnt <= last_row ? '0 : row_cnt + RW'(1);
      end else begin
        col_cnt <= col_cnt + CW'(1);
      end
    end
  end

  logic          s1_valid, s1_eol, s1_eof;
  logic [SW-1:0] gx_pos, gx_neg, gy_pos, gy_neg;

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      s1_valid <= 1'b0;
      s1_eol   <= 1'b0;
      s1_eof   <= 1'b0;
      gx_pos   <= '0;
      gx_neg   <= '0;
      gy_pos   <= '0;
      gy_neg   <= '0;
    end else begin
      s1_valid <= qual;
      s1_eol   <= qual && last_col;
      s1_eof   <= qual && last_col && last_row;
      if (qual) begin
        gx_pos <= p[0][2] + (p[1][2] << 1) + p[2][2];
        gx_neg <= p[0][0] + (p[1][0] << 1) + p[2][0];
        gy_pos <= p[2][0] + (p[2][1] << 1) + p[2][2];
        gy_neg <= p[0][0] + (p[0][1] << 1) + p[0][2];
      end
    end
  end

  logic               s2_valid, s2_eol, s2_eof;
  logic [SW-1:0]      abs_gx, abs_gy;
  logic signed [SW:0] gx, gy;

  assign gx = $signed({1'b0, gx_pos}) - $signed({1'b0, gx_neg});
  assign gy = $signed({1'b0, gy_pos}) - $signed({1'b0, gy_neg});

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      s2_valid <= 1'b0;
      s2_eol   <= 1'b0;
      s2_eof   <= 1'b0;
      abs_gx   <= '0;
      abs_gy   <= '0;
    end else begin
      s2_valid <= s1_valid;
      s2_eol   <= s1_eol;
      s2_eof   <= s1_eof;
      if (s1_valid) begin
        abs_gx <= gx[SW] ? SW'(-gx) : SW'(gx);
        abs_gy <= gy[SW] ? SW'(-gy) : SW'(gy);
      end
    end
  end

  logic [SW:0]          sum;
  logic [ITEM_SIZE-1:0] sat;

  assign sum = {1'b0, abs_gx} + {1'b0, abs_gy};
  assign sat = (|sum[SW:ITEM_SIZE]) ? '1 : sum[ITEM_SIZE-1:0];

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      edge_valid <= 1'b0;
      edge_eol   <= 1'b0;
      edge_eof   <= 1'b0;
      edge_mag   <= '0;
      edge_bit   <= 1'b0;
    end else begin
      edge_valid <= s2_valid;
      edge_eol   <= s2_eol;
      edge_eof   <= s2_eof;
      if (s2_valid) begin
        edge_mag <= sat;
        edge_bit <= (sat > threshold);
      end
    end
  end

endmodule

// File: tb/tb_sobel_edge_filter.sv
// Scoreboard bench for sobel_edge_filter: directed rows with hand-computed
// magnitudes, a reduced frame height, valid gaps and a mid-row reset.
module tb_sobel_edge_filter;

  localparam int W = 512;
  localparam int H = 6;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic [71:0] win = '0;
  logic        vin = 1'b0;
  logic [7:0]  thr = '0;
  logic [7:0]  edge_mag;
  logic        edge_bit, edge_valid, edge_eol, edge_eof;

  sobel_edge_filter #(
    .ITEM_SIZE(8),
    .IMAGE_WIDTH(W),
    .IMAGE_HEIGHT(H)
  ) dut (
    .clk(clk),
    .rstN(rstN),
    .window_in(win),
    .window_in_valid(vin),
    .threshold(thr),
    .edge_mag(edge_mag),
    .edge_bit(edge_bit),
    .edge_valid(edge_valid),
    .edge_eol(edge_eol),
    .edge_eof(edge_eof)
  );

  always #5 clk = ~clk;

  typedef struct {
    int mag;
    bit b;
    bit eol;
    bit eof;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   eof_seen = 0;
  int   bcol = 0;
  int   brow = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [71:0] mk(input int v[9]);
    logic [71:0] w;
    for (int i = 0; i < 9; i++) w[i*8 +: 8] = 8'(v[i]);
    return w;
  endfunction

  function automatic logic [71:0] cols(input int a, input int b, input int c);
    int v[9];
    for (int r = 0; r < 3; r++) begin
      v[3*r] = a; v[3*r+1] = b; v[3*r+2] = c;
    end
    return mk(v);
  endfunction

  function automatic logic [71:0] rows(input int a, input int b, input int c);
    int v[9];
    for (int k = 0; k < 3; k++) begin
      v[k] = a; v[3+k] = b; v[6+k] = c;
    end
    return mk(v);
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic beat(input logic [71:0] w, input int mag);
    bit eol;
    exp_t e;
    @(negedge clk);
    win = w;
    vin = 1'b1;
    eol = (bcol == W - 1);
    if (bcol >= 2) begin
      e.mag = mag;
      e.b   = (mag > int'(thr));
      e.eol = eol;
      e.eof = eol && (brow == H - 3);
      e.cyc = cyc + 3;
      q.push_back(e);
    end
    if (eol) begin
      bcol = 0;
      brow = (brow == H - 3) ? 0 : brow + 1;
    end else begin
      bcol++;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      vin = 1'b0;
    end
  endtask

  task automatic row_of(input logic [71:0] w, input int mag, input bit gaps);
    for (int i = 0; i < W; i++) begin
      beat(w, mag);
      if (gaps) idle(1);
    end
    idle(4);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rstN) begin
      if (!edge_valid && (edge_eol || edge_eof)) begin
        checks++;
        failures++;
        $display("FAIL tag_without_valid eol=%0b eof=%0b", edge_eol, edge_eof);
      end
      if (edge_valid) begin
        checks++;
        if (edge_eof) eof_seen++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_output cyc=%0d mag=%0d", cyc, edge_mag);
        end else begin
          e = q.pop_front();
          if (int'(edge_mag) != e.mag || edge_bit != e.b ||
              edge_eol != e.eol || edge_eof != e.eof || cyc != e.cyc) begin
            failures++;
            $display("FAIL output actual mag=%0d bit=%0b eol=%0b eof=%0b cyc=%0d required mag=%0d bit=%0b eol=%0b eof=%0b cyc=%0d",
                     edge_mag, edge_bit, edge_eol, edge_eof, cyc,
                     e.mag, e.b, e.eol, e.eof, e.cyc);
          end
        end
      end
    end
  end

  logic [71:0] mixw[5];
  int          mixm[5];

  initial begin
    mixw[0] = mk('{0, 0, 0, 0, 0, 5, 0, 0, 0});
    mixm[0] = 10;
    mixw[1] = mk('{0, 7, 0, 0, 0, 0, 0, 0, 0});
    mixm[1] = 14;
    mixw[2] = mk('{0, 0, 0, 0, 0, 10, 0, 10, 20});
    mixm[2] = 80;
    mixw[3] = mk('{20, 10, 0, 10, 0, 0, 0, 0, 0});
    mixm[3] = 80;
    mixw[4] = mk('{0, 0, 0, 0, 0, 0, 200, 0, 0});
    mixm[4] = 255;

    #12;
    chk("reset_valid", int'(edge_valid), 0);
    chk("reset_mag", int'(edge_mag), 0);
    chk("reset_bit", int'(edge_bit), 0);
    chk("reset_eol", int'(edge_eol), 0);
    chk("reset_eof", int'(edge_eof), 0);
    @(negedge clk);
    rstN = 1'b1;

    thr = 8'd0;
    row_of(cols(10, 10, 10), 0, 1'b0);
    thr = 8'd200;
    row_of(cols(0, 255, 255), 255, 1'b0);
    thr = 8'd100;
    row_of(cols(0, 10, 20), 80, 1'b0);
    thr = 8'd80;
    row_of(cols(0, 10, 20), 80, 1'b0);
    chk("eof_after_frame", eof_seen, 1);
    thr = 8'd79;
    row_of(cols(0, 10, 20), 80, 1'b0);
    thr = 8'd200;
    row_of(rows(0, 255, 255), 255, 1'b1);
    thr = 8'd13;
    for (int i = 0; i < W; i++) beat(mixw[i % 5], mixm[i % 5]);
    idle(4);

    for (int i = 0; i < 300; i++) beat(cols(0, 10, 20), 80);
    @(posedge clk);
    #1;
    chk("pre_reset_valid", int'(edge_valid), 1);
    rstN = 1'b0;
    vin = 1'b0;
    #1;
    chk("async_reset_valid", int'(edge_valid), 0);
    chk("async_reset_mag", int'(edge_mag), 0);
    chk("async_reset_bit", int'(edge_bit), 0);
    q.delete();
    bcol = 0;
    brow = 0;
    @(negedge clk);
    rstN = 1'b1;
    thr = 8'd79;
    row_of(cols(0, 10, 20), 80, 1'b0);

    idle(6);
    chk("scoreboard_drained", q.size(), 0);
    chk("eof_total", eof_seen, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
